// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a DEPTH-entry fetch buffer.
// Optional misaligned-PC detection is enabled with `define IFETCH_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module ifetch_unit #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] pc,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fault
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDrop
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [31:0]     pending_pc_q, pending_pc_d;
   logic            fault_q, fault_d;

   logic [31:0] buf_inst_q [DEPTH];
   logic [31:0] buf_pc_q   [DEPTH];

   logic has_space;
   logic can_issue;
   logic misalign;
   logic mis_drop;
   logic issue;
   logic push;
   logic pop;

   // Request side and FIFO handshakes
   always_comb begin
      has_space = count_q < DepthC;
      can_issue = (state_q == StIdle) && !flush && has_space;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign  = pc_valid && (pc[1:0] != 2'b00);
`else
      misalign  = 1'b0;
`endif
      mis_drop   = can_issue && misalign;
      imem_req   = pc_valid && can_issue && !misalign;
      imem_addr  = pc;
      pc_ready   = can_issue && (imem_gnt || misalign);
      issue      = imem_req && imem_gnt;
      // Responses landing in WAIT together with a flush are discarded, never buffered.
      push       = (state_q == StWait) && imem_rvalid && !flush;
      inst_valid = (count_q != '0);
      pop        = inst_valid && inst_ready && !flush;
   end

   always_comb begin
      state_d      = state_q;
      pending_pc_d = pending_pc_q;
      case (state_q)
         StIdle: begin
            if (issue) begin
               state_d      = StWait;
               pending_pc_d = pc;
            end
         end
         StWait: begin
            if (imem_rvalid) begin
               state_d = StIdle;
            end else if (flush) begin
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (imem_rvalid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      fault_d = fault_q;
      if (flush) begin
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
         fault_d = 1'b0;
      end else begin
         // Pointers are PtrW wide and DEPTH is a power of two, so they wrap on their own.
         wptr_d  = wptr_q + PtrW'(push);
         rptr_d  = rptr_q + PtrW'(pop);
         count_d = count_q + CntW'(push) - CntW'(pop);
         if (mis_drop) begin
            fault_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= StIdle;
         count_q      <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         pending_pc_q <= '0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         pending_pc_q <= pending_pc_d;
         fault_q      <= fault_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_inst_q[wptr_q] <= imem_rdata;
         buf_pc_q[wptr_q]   <= pending_pc_q;
      end
   end

   // Storage is not reset; an empty buffer reads as zero instead.
   always_comb begin
      inst    = inst_valid ? buf_inst_q[rptr_q] : 32'h0;
      inst_pc = inst_valid ? buf_pc_q[rptr_q]   : 32'h0;
      fault   = fault_q;
   end

   assert property (@(posedge clk) disable iff (clr) count_q <= DepthC);
   assert property (@(posedge clk) disable iff (clr) !(push && !pop && (count_q == DepthC)));
   assert property (@(posedge clk) disable iff (clr) (state_q != StIdle) |-> !imem_req);

endmodule
